// File: rtl/serial_tx_cfg.sv
// serial_tx_cfg: parametrised RS-232 transmitter with a one-entry holding register
// so frames can go back to back. Define UART_TX_PARITY_EN to insert a parity bit.
module serial_tx_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 baud_rate_tick_i,
    input  logic                 valid_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 transmit_o
);

    localparam int unsigned          BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state_q,     state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic                 stop_cnt_q,  stop_cnt_d;
    logic [DATA_BITS-1:0] shifter_q,   shifter_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_q,        tx_d;
    logic                 done_c;

`ifdef UART_TX_PARITY_EN
    logic parity_c;
    assign parity_c = (^shifter_d) ^ 1'(PARITY_ODD);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    // Holding register, frame sequencing and counters
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_c      = 1'b0;

        // Loads below only fire with hold_full_q=1, so they never race an accept
        if (valid_i && !hold_full_q) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (baud_rate_tick_i && hold_full_q) begin
                    shifter_d   = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (baud_rate_tick_i) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_rate_tick_i) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = ST_PARITY;
`else
                        state_d    = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_rate_tick_i) begin
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_rate_tick_i) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_c     = 1'b1;
                        stop_cnt_d = 1'b0;
                        if (hold_full_q) begin
                            shifter_d   = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
    end

    // Line level follows the next state so each bit starts on the edge after a tick
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shifter_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_c;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shifter_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shifter_q   <= shifter_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    assign ready_o    = ~hold_full_q;
    assign busy_o     = (state_q != ST_IDLE) | hold_full_q;
    assign done_o     = done_c;
    assign transmit_o = tx_q;

endmodule

// File: tb/tb_serial_tx_cfg.sv
// Directed bench for serial_tx_cfg: default 8N1 instance, 5-bit/2-stop instance and
// an odd-parity instance; expected line bits are hand-written or built from frame rules.
module tb_serial_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FL8 = 1 + 8 + PAR_EN + 1;
    localparam int FL5 = 1 + 5 + PAR_EN + 2;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       valid_a, valid_b, valid_c;
    logic [7:0] data_a, data_c;
    logic [4:0] data_b;
    logic       ready_a, busy_a, done_a, tx_a;
    logic       ready_b, busy_b, done_b, tx_b;
    logic       ready_c, busy_c, done_c, tx_c;

    int tests = 0;
    int fails = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int tick_phase;

    serial_tx_cfg dut_a (
        .sysclk(sysclk), .reset_n(reset_n), .baud_rate_tick_i(tick),
        .valid_i(valid_a), .data_i(data_a), .ready_o(ready_a),
        .busy_o(busy_a), .done_o(done_a), .transmit_o(tx_a)
    );

    serial_tx_cfg #(.DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .sysclk(sysclk), .reset_n(reset_n), .baud_rate_tick_i(tick),
        .valid_i(valid_b), .data_i(data_b), .ready_o(ready_b),
        .busy_o(busy_b), .done_o(done_b), .transmit_o(tx_b)
    );

    serial_tx_cfg #(.PARITY_ODD(1)) dut_c (
        .sysclk(sysclk), .reset_n(reset_n), .baud_rate_tick_i(tick),
        .valid_i(valid_c), .data_i(data_c), .ready_o(ready_c),
        .busy_o(busy_c), .done_o(done_c), .transmit_o(tx_c)
    );

    always #5 sysclk = ~sysclk;

    // One-cycle tick every 16 clocks, changed shortly after the rising edge
    initial begin
        tick       = 1'b0;
        tick_phase = 0;
        forever begin
            @(posedge sysclk);
            #2;
            tick_phase = (tick_phase + 1) % 16;
            tick       = (tick_phase == 15);
        end
    end

    always @(negedge sysclk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_rdy(input int sel);
        case (sel)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    // Writes one frame into an idle-high bit vector starting at line bit pos
    function automatic logic [39:0] add_frame(input logic [39:0] base, input int pos,
                                              input logic [8:0] d, input int dbits,
                                              input int sbits, input int odd);
        logic [39:0] f;
        logic        par;
        int          p;
        f      = base;
        f[pos] = 1'b0;
        par    = (odd != 0);
        for (int i = 0; i < dbits; i++) begin
            f[pos + 1 + i] = d[i];
            par            = par ^ d[i];
        end
        p = pos + 1 + dbits;
        if (PAR_EN != 0) begin
            f[p] = par;
            p++;
        end
        for (int s = 0; s < sbits; s++) f[p + s] = 1'b1;
        return f;
    endfunction

    task automatic step();
        @(posedge sysclk);
        #2;
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        step();
        case (sel)
            0:       begin valid_a = 1'b1; data_a = d;      end
            1:       begin valid_b = 1'b1; data_b = d[4:0]; end
            default: begin valid_c = 1'b1; data_c = d;      end
        endcase
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    // Waits for a start bit, then samples nbits line bits mid-bit
    task automatic capture(input int sel, input int nbits, output logic [39:0] bits,
                           output logic [39:0] rdy, output bit found);
        int w;
        bits  = '1;
        rdy   = '1;
        found = 1'b0;
        w     = 0;
        @(negedge sysclk);
        while (get_tx(sel) !== 1'b0 && w < 200) begin
            @(negedge sysclk);
            w++;
        end
        if (get_tx(sel) === 1'b0) begin
            found = 1'b1;
            for (int i = 0; i < nbits; i++) begin
                repeat ((i == 0) ? 8 : 16) @(negedge sysclk);
                bits[i] = get_tx(sel);
                rdy[i]  = get_rdy(sel);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge sysclk);
        tests++;
        if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_a: got tx/rdy/busy/done=%b want 1100", {tx_a, ready_a, busy_a, done_a});
        end
        tests++;
        if ({tx_b, ready_b, busy_b, done_b} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_b: got tx/rdy/busy/done=%b want 1100", {tx_b, ready_b, busy_b, done_b});
        end
        step();
        reset_n = 1'b1;
        repeat (20) step();
        @(negedge sysclk);
        tests++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            fails++;
            $display("FAIL idle_ticks: got tx/rdy/busy=%b want 110", {tx_a, ready_a, busy_a});
        end
    endtask

    task automatic test_basic_frame();
        logic [39:0] bits, rdy, exp;
        bit          found;
        int          d0, w;
`ifdef UART_TX_PARITY_EN
        exp = {29'h1FFF_FFFF, 11'b100_1010_1010};
`else
        exp = {30'h3FFF_FFFF, 10'b10_1010_1010};
`endif
        d0 = done_cnt_a;
        send(0, 8'h55);
        capture(0, FL8, bits, rdy, found);
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL frame_55: got %h want %h (start seen %0d)", bits, exp, found);
        end
        w = 0;
        @(negedge sysclk);
        while (done_a !== 1'b1 && w < 20) begin
            @(negedge sysclk);
            w++;
        end
        tests++;
        if (done_a !== 1'b1 || busy_a !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse: got done=%b busy=%b want done=1 busy=1", done_a, busy_a);
        end
        @(negedge sysclk);
        tests++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL busy_drop: got done=%b busy=%b want 0 0", done_a, busy_a);
        end
        step();
        tests++;
        if (done_cnt_a - d0 !== 1) begin
            fails++;
            $display("FAIL done_count: got %0d want 1", done_cnt_a - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] bits, rdy, exp;
        bit          found;
        logic        r;
        exp = add_frame('1, 0, 9'h0A5, 8, 1, 0);
        exp = add_frame(exp, FL8, 9'h03C, 8, 1, 0);
        r   = 1'b1;
        fork
            capture(0, 2 * FL8, bits, rdy, found);
            begin
                send(0, 8'hA5);
                repeat (40) step();
                send(0, 8'h3C);
                @(negedge sysclk);
                r = ready_a;
            end
        join
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL b2b_line: got %h want %h", bits, exp);
        end
        tests++;
        if (r !== 1'b0 || rdy[FL8 - 1] !== 1'b0 || rdy[FL8] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: got accept=%b stop=%b start2=%b want 0 0 1", r, rdy[FL8 - 1], rdy[FL8]);
        end
    endtask

    task automatic test_hold_full();
        logic [39:0] bits, rdy, exp;
        bit          found;
        logic        r;
        exp = add_frame('1, 0, 9'h011, 8, 1, 0);
        exp = add_frame(exp, FL8, 9'h022, 8, 1, 0);
        r   = 1'b1;
        fork
            capture(0, 3 * FL8, bits, rdy, found);
            begin
                send(0, 8'h11);
                repeat (40) step();
                send(0, 8'h22);
                @(negedge sysclk);
                r = ready_a;
                send(0, 8'h33);
            end
        join
        tests++;
        if (r !== 1'b0) begin
            fail_line: begin
                fails++;
                $display("FAIL hold_ready: got ready=%b want 0", r);
            end
        end
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL hold_drop: got %h want %h", bits, exp);
        end
    endtask

    task automatic test_parity();
        logic [39:0] bits, rdy, exp;
        bit          found;
`ifdef UART_TX_PARITY_EN
        exp = {29'h1FFF_FFFF, 11'b110_0000_1110};
`else
        exp = {30'h3FFF_FFFF, 10'b10_0000_1110};
`endif
        send(0, 8'h07);
        capture(0, FL8, bits, rdy, found);
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL parity_even_07: got %h want %h", bits, exp);
        end
        repeat (24) step();
`ifdef UART_TX_PARITY_EN
        exp = {29'h1FFF_FFFF, 11'b100_0000_1110};
`else
        exp = {30'h3FFF_FFFF, 10'b10_0000_1110};
`endif
        send(2, 8'h07);
        capture(2, FL8, bits, rdy, found);
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL parity_odd_07: got %h want %h", bits, exp);
        end
        repeat (24) step();
    endtask

    task automatic test_5bit_2stop();
        logic [39:0] bits, rdy, exp;
        bit          found;
        int          d0, early, w;
`ifdef UART_TX_PARITY_EN
        exp = {31'h7FFF_FFFF, 9'b1_1111_1110};
`else
        exp = {32'hFFFF_FFFF, 8'b1111_1110};
`endif
        d0 = done_cnt_b;
        send(1, 8'h1F);
        capture(1, FL5, bits, rdy, found);
        #1;
        early = done_cnt_b - d0;
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL frame5_1F: got %h want %h", bits, exp);
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL done_first_stop: got %0d pulses in 2nd stop bit want 0", early);
        end
        w = 0;
        @(negedge sysclk);
        while (done_b !== 1'b1 && w < 20) begin
            @(negedge sysclk);
            w++;
        end
        step();
        tests++;
        if (done_cnt_b - d0 !== 1) begin
            fails++;
            $display("FAIL done_second_stop: got %0d pulses want 1", done_cnt_b - d0);
        end
        exp = add_frame('1, 0, 9'h012, 5, 2, 0);
        send(1, 8'h12);
        capture(1, FL5, bits, rdy, found);
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL frame5_12: got %h want %h", bits, exp);
        end
        repeat (24) step();
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] bits, rdy, exp;
        bit          found, any_low;
        int          w;
        send(0, 8'h00);
        w = 0;
        @(negedge sysclk);
        while (tx_a !== 1'b0 && w < 40) begin
            @(negedge sysclk);
            w++;
        end
        repeat (8) @(negedge sysclk);
        send(0, 8'h00);
        repeat (62) @(negedge sysclk);
        tests++;
        if (tx_a !== 1'b0 || ready_a !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_bit3: got tx=%b ready=%b want 0 0", tx_a, ready_a);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            fails++;
            $display("FAIL async_reset: got tx/rdy/busy=%b want 110", {tx_a, ready_a, busy_a});
        end
        repeat (2) step();
        reset_n = 1'b1;
        any_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) any_low = 1'b1;
        end
        tests++;
        if (any_low) begin
            fails++;
            $display("FAIL held_discarded: got activity after reset want idle line");
        end
        exp = add_frame('1, 0, 9'h05A, 8, 1, 0);
        send(0, 8'h5A);
        capture(0, FL8, bits, rdy, found);
        tests++;
        if (!found || bits !== exp) begin
            fails++;
            $display("FAIL post_reset_frame: got %h want %h", bits, exp);
        end
        repeat (24) step();
    endtask

    initial begin
        reset_n = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        data_a  = '0;
        data_b  = '0;
        data_c  = '0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        repeat (24) step();
        test_hold_full();
        repeat (24) step();
        test_parity();
        test_5bit_2stop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
